// File: rtl/bootram_bus_arbiter.sv
// Arbitrates the 4-lane boot RAM between the CPU port and the byte loader; all RAM pins are registered.
// Latency: cpu_ready 3 cycles after grant (4-cycle slot), ld_ready 2 cycles after grant (3-cycle slot).
// Backpressure: requesters hold valid until their ready pulse; ld_lock blocks new CPU grants.
module bootram_bus_arbiter #(
    parameter int AW          = 11,
    parameter bit LOADER_PRIO = 1'b1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cpu_valid,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [3:0]    cpu_wstrb,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_ready,
    input  logic          ld_valid,
    input  logic [AW+1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    input  logic          ld_lock,
    output logic          busy,
    output logic          ram_ce,
    output logic          ram_oce,
    output logic [3:0]    ram_wre,
    output logic [AW-1:0] ram_ad,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout
);

    typedef enum logic [2:0] {
        IDLE, CPU_ACC, CPU_RSP, CPU_END, LD_ACC, LD_END
    } state_t;

    state_t        state, state_nxt;
    logic          ce_nxt, cpu_ready_nxt, ld_ready_nxt;
    logic [3:0]    wre_nxt;
    logic [AW-1:0] ad_nxt;
    logic [31:0]   din_nxt, rdata_nxt;
    logic          cpu_req, ld_req, cpu_win, ld_win;

    // Byte-offset and high address bits alias onto the same word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

    assign cpu_req = cpu_valid & ~ld_lock;
    assign ld_req  = ld_valid;
    assign ld_win  = ld_req & (~cpu_req | LOADER_PRIO);
    assign cpu_win = cpu_req & ~ld_win;

    assign busy    = (state != IDLE);
    assign ram_oce = 1'b1;

    always_comb begin
        state_nxt     = state;
        ce_nxt        = 1'b0;
        wre_nxt       = 4'b0000;
        ad_nxt        = ram_ad;
        din_nxt       = ram_din;
        rdata_nxt     = cpu_rdata;
        cpu_ready_nxt = 1'b0;
        ld_ready_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (ld_win) begin
                    ce_nxt    = 1'b1;
                    ad_nxt    = ld_addr[AW+1:2];
                    din_nxt   = {4{ld_data}};
                    wre_nxt   = 4'b0001 << ld_addr[1:0];
                    state_nxt = LD_ACC;
                end else if (cpu_win) begin
                    ce_nxt    = 1'b1;
                    ad_nxt    = cpu_addr[AW+1:2];
                    din_nxt   = cpu_wdata;
                    wre_nxt   = cpu_wstrb;
                    state_nxt = CPU_ACC;
                end
            end
            CPU_ACC: state_nxt = CPU_RSP;
            CPU_RSP: begin
                rdata_nxt     = ram_dout;
                cpu_ready_nxt = 1'b1;
                state_nxt     = CPU_END;
            end
            CPU_END: state_nxt = IDLE;
            LD_ACC: begin
                ld_ready_nxt = 1'b1;
                state_nxt    = LD_END;
            end
            LD_END:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            ram_ce    <= 1'b0;
            ram_wre   <= 4'b0000;
            ram_ad    <= '0;
            ram_din   <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            ld_ready  <= 1'b0;
        end else begin
            state     <= state_nxt;
            ram_ce    <= ce_nxt;
            ram_wre   <= wre_nxt;
            ram_ad    <= ad_nxt;
            ram_din   <= din_nxt;
            cpu_rdata <= rdata_nxt;
            cpu_ready <= cpu_ready_nxt;
            ld_ready  <= ld_ready_nxt;
        end
    end

endmodule

// File: tb/tb_bootram_bus_arbiter.sv
// Bench for bootram_bus_arbiter: directed scenarios plus random CPU/loader traffic against a byte-level memory model.
module tb_bootram_bus_arbiter;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cpu_valid, cpu_ready, ld_valid, ld_ready, ld_lock, busy;
    logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]    cpu_wstrb;
    logic [AW+1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          ram_ce, ram_oce;
    logic [3:0]    ram_wre;
    logic [AW-1:0] ram_ad;
    logic [31:0]   ram_din, ram_dout;

    int n_chk = 0;
    int n_err = 0;

    // Reference: plain byte-addressed memory image.
    logic [7:0]  ref_mem [0:(4<<AW)-1];
    // Physical RAM stand-in: read-before-write, four byte lanes.
    logic [31:0] ram_mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ce) begin
            ram_dout <= ram_mem[ram_ad];
            for (int l = 0; l < 4; l++)
                if (ram_wre[l]) ram_mem[ram_ad][8*l +: 8] <= ram_din[8*l +: 8];
        end
    end

    bootram_bus_arbiter #(.AW(AW), .LOADER_PRIO(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_lock(ld_lock), .busy(busy),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    function automatic logic [31:0] alias_addr(input int w);
        logic [31:0] r;
        r = $urandom;
        r[AW+1:2] = w[AW-1:0];
        return r;
    endfunction

    // Issue one CPU access from a negedge; exp_lat counts cycles until cpu_ready is seen.
    task automatic cpu_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int exp_lat, input string tag);
        int n;
        int w;
        w = int'(addr[AW+1:2]);
        cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb; cpu_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_ready && n < 50);
        cpu_valid = 1'b0;
        chk({tag, "_lat"}, n, exp_lat);
        if (wstrb == 4'b0000)
            chk({tag, "_rd"}, cpu_rdata, ref_word(w));
        else
            for (int l = 0; l < 4; l++)
                if (wstrb[l]) ref_mem[4*w+l] = wdata[8*l +: 8];
    endtask

    task automatic ld_txn(input logic [AW+1:0] a, input logic [7:0] d, input int exp_lat, input string tag);
        int n;
        ld_addr = a; ld_data = d; ld_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ld_ready && n < 50);
        ld_valid = 1'b0;
        chk({tag, "_lat"}, n, exp_lat);
        ref_mem[a] = d;
    endtask

    initial begin
        int n, seen, w1, w2, op;
        cpu_valid = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0; ld_lock = 0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ce", ram_ce, 0);
        chk("rst_wre", ram_wre, 0);
        chk("rst_ad", ram_ad, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_cready", cpu_ready, 0);
        chk("rst_lready", ld_ready, 0);
        chk("rst_oce", ram_oce, 1);
        resetn = 1'b1;
        @(negedge clk);

        // Full-word write then read back
        cpu_txn(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3, "t1_wr");
        @(negedge clk);
        cpu_txn(32'h0000_0010, 32'h0, 4'h0, 3, "t1_rd");
        chk("t1_val", cpu_rdata, 32'hDEAD_BEEF);

        // Single-lane partial write
        @(negedge clk);
        cpu_txn(32'h0000_0010, 32'h00AA_0000, 4'b0100, 3, "t2_wr");
        @(negedge clk);
        cpu_txn(32'h0000_0010, 32'h0, 4'h0, 3, "t2_rd");
        chk("t2_val", cpu_rdata, 32'hDEAA_BEEF);

        // Loader burst with valid held: one byte every 3 cycles
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            ld_addr = (AW+2)'(i);
            ld_data = 8'(17 * (i + 1));
            ld_valid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!ld_ready && n < 50);
            chk($sformatf("t3_gap%0d", i), n, (i == 0) ? 2 : 3);
            ref_mem[i] = ld_data;
        end
        ld_valid = 1'b0;
        @(negedge clk);
        cpu_txn(32'h0, 32'h0, 4'h0, 3, "t3_rd");
        chk("t3_val", cpu_rdata, 32'h4433_2211);

        // Simultaneous requests: loader first, CPU read sees the loader's byte
        @(negedge clk);
        fork
            cpu_txn(32'h0, 32'h0, 4'h0, 6, "t4_cpu");
            ld_txn((AW+2)'(1), 8'h5A, 2, "t4_ld");
        join
        chk("t4_val", cpu_rdata, 32'h4433_5A11);

        // Lock stalls the CPU with the RAM idle
        @(negedge clk);
        ld_lock = 1'b1;
        cpu_addr = 32'h10; cpu_wstrb = 4'h0; cpu_valid = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (cpu_ready || ram_ce || busy) seen++;
        end
        chk("t5_stall", seen, 0);
        ld_lock = 1'b0;
        cpu_txn(32'h10, 32'h0, 4'h0, 3, "t5_rd");

        // Reset during CPU_ACC drops the write before the RAM samples it
        @(negedge clk);
        cpu_addr = 32'h10; cpu_wdata = 32'h1234_5678; cpu_wstrb = 4'hF; cpu_valid = 1'b1;
        @(negedge clk);
        chk("t6_ce_pre", ram_ce, 1);
        resetn = 1'b0;
        #1;
        chk("t6_ce", ram_ce, 0);
        chk("t6_wre", ram_wre, 0);
        chk("t6_ad", ram_ad, 0);
        chk("t6_din", ram_din, 0);
        chk("t6_rdata", cpu_rdata, 0);
        chk("t6_busy", busy, 0);
        cpu_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("t6_busy_post", busy, 0);
        cpu_txn(32'h10, 32'h0, 4'h0, 3, "t6_rd");
        chk("t6_val", cpu_rdata, 32'hDEAA_BEEF);

        // Random traffic over 16 words, aliased CPU addresses
        for (int w = 0; w < 16; w++) begin
            @(negedge clk);
            cpu_txn(alias_addr(w), $urandom, 4'hF, 3, "pre");
        end
        for (int k = 0; k < 150; k++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            w1 = int'($urandom_range(0, 15));
            w2 = int'($urandom_range(0, 15));
            op = int'($urandom_range(0, 3));
            case (op)
                0: cpu_txn(alias_addr(w1), 32'h0, 4'h0, 3, "r_rd");
                1: cpu_txn(alias_addr(w1), $urandom, 4'($urandom_range(1, 15)), 3, "r_wr");
                2: ld_txn((AW+2)'(4*w1 + int'($urandom_range(0, 3))), 8'($urandom), 2, "r_ld");
                default: fork
                    cpu_txn(alias_addr(w1), 32'h0, 4'h0, 6, "r_ccpu");
                    ld_txn((AW+2)'(4*w2 + int'($urandom_range(0, 3))), 8'($urandom), 2, "r_cld");
                join
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
